// File: rtl/int_to_fp_if.sv
// Handshake and result bundle between an integer producer and the int_to_fp converter.
// The slave modport is the converter's view; the master modport is the producer/consumer's view.
interface int_to_fp_if #(
    parameter int INT_W = 12
) ();
    logic             in_valid;
    logic             in_ready;
    logic [INT_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             sign_out;
    logic [3:0]       exp_out;
    logic [7:0]       frac_out;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, sign_out, exp_out, frac_out
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, frac_out
    );
endinterface

// File: rtl/int_to_fp.sv
// Serial signed-integer to 13-bit float converter (sign, 4-bit exponent, 8-bit 0.frac mantissa).
// Normalizes by shifting the magnitude left one bit per clock until its MSB is set.
module int_to_fp #(
    parameter int INT_W = 12
) (
    input logic        clk,
    input logic        reset,
    int_to_fp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ABS, NORM, DONE} state_t;

    localparam logic [3:0] EXP_INIT = 4'(INT_W);

    state_t           state;
    state_t           next_state;
    logic [INT_W-1:0] data_reg;
    logic [INT_W-1:0] mag;
    logic             sign_reg;
    logic [3:0]       exp_reg;
    logic             sign_q;
    logic [3:0]       exp_q;
    logic [7:0]       frac_q;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sign_out  = sign_q;
    assign bus.exp_out   = exp_q;
    assign bus.frac_out  = frac_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.in_valid) next_state = ABS;
            ABS:  next_state = NORM;
            NORM: if (mag[INT_W-1] || (mag == '0)) next_state = DONE;
            DONE: if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The most negative input negates to 2^(INT_W-1), which is still correct read as unsigned.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= '0;
            sign_reg <= 1'b0;
            mag      <= '0;
            exp_reg  <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            frac_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_reg <= bus.in_data;
                        sign_reg <= bus.in_data[INT_W-1];
                    end
                end
                ABS: begin
                    mag     <= sign_reg ? (~data_reg + 1'b1) : data_reg;
                    exp_reg <= EXP_INIT;
                end
                NORM: begin
                    if (mag[INT_W-1]) begin
                        frac_q <= mag[INT_W-1 -: 8];
                        exp_q  <= exp_reg;
                        sign_q <= sign_reg;
                    end else if (mag == '0) begin
                        frac_q <= '0;
                        exp_q  <= '0;
                        sign_q <= 1'b0;
                    end else begin
                        mag     <= mag << 1;
                        exp_reg <= exp_reg - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: directed vector table, hand-written corner sequences,
// and random integers checked against an arithmetic reference model.
module tb_int_to_fp;
    localparam int INT_W = 12;

    typedef struct {
        logic       s;
        logic [3:0] e;
        logic [7:0] f;
        int         lat;
    } result_t;

    typedef struct {
        logic [INT_W-1:0] data;
        result_t          want;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    int_to_fp_if #(.INT_W(INT_W)) bus ();

    int_to_fp #(.INT_W(INT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: value = 0.frac * 2^exp with the smallest exponent that holds |v|, truncated.
    function automatic result_t model(input logic [INT_W-1:0] d);
        result_t r;
        int v;
        int m;
        int e;
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        if (m == 0) begin
            r.s = 1'b0;
            r.e = 4'd0;
            r.f = 8'd0;
            r.lat = 3;
        end else begin
            e = 0;
            while ((1 << e) <= m) e++;
            r.s = (v < 0);
            r.e = 4'(e);
            r.f = 8'((m * 256) / (1 << e));
            r.lat = 3 + INT_W - e;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the output handshake.
    task automatic applyStimulus(input logic [INT_W-1:0] d, input result_t want, input int hold,
                                 input bit keep_valid, input logic [INT_W-1:0] next_data,
                                 input string name);
        int  cyc;
        bit  got;
        checkOutput({name, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        if (keep_valid) bus.in_data = next_data;
        else bus.in_valid = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            checkOutput({name, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
        end
        checkOutput({name, " latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(want.lat));
        if (!got) return;
        checkOutput({name, " sign"}, 32'(bus.sign_out), 32'(want.s));
        checkOutput({name, " exp"},  32'(bus.exp_out),  32'(want.e));
        checkOutput({name, " frac"}, 32'(bus.frac_out), 32'(want.f));
        checkOutput({name, " in_ready done"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({name, " hold valid"}, 32'(bus.out_valid), 32'd1);
            checkOutput({name, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
            checkOutput({name, " hold result"}, {19'd0, bus.sign_out, bus.exp_out, bus.frac_out},
                        {19'd0, want.s, want.e, want.f});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput({name, " valid drop"}, 32'(bus.out_valid), 32'd0);
        checkOutput({name, " in_ready back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        vec_t    vecs[7];
        result_t want;
        logic [INT_W-1:0] d;
        int      pulses;

        vecs[0] = '{12'h001, '{1'b0, 4'd1,  8'h80, 14}};
        vecs[1] = '{12'h800, '{1'b1, 4'd12, 8'h80, 3}};
        vecs[2] = '{12'h064, '{1'b0, 4'd7,  8'hC8, 8}};
        vecs[3] = '{12'h7FF, '{1'b0, 4'd11, 8'hFF, 4}};
        vecs[4] = '{12'hF9C, '{1'b1, 4'd7,  8'hC8, 8}};
        vecs[5] = '{12'h000, '{1'b0, 4'd0,  8'h00, 3}};
        vecs[6] = '{12'hFFF, '{1'b1, 4'd1,  8'h80, 14}};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset result", {19'd0, bus.sign_out, bus.exp_out, bus.frac_out}, 32'd0);
        reset = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].data, vecs[i].want, 0, 1'b0, '0, $sformatf("vec%0d", i));
        end

        $display("[TB] continuous in_valid: only one sample per conversion");
        applyStimulus(12'h000, vecs[5].want, 0, 1'b1, 12'h123, "cont zero");
        applyStimulus(12'h123, model(12'h123), 0, 1'b0, '0, "cont next");

        $display("[TB] backpressure in DONE");
        applyStimulus(12'h064, vecs[2].want, 5, 1'b0, '0, "backpressure");

        $display("[TB] reset during normalization");
        bus.in_valid = 1'b1;
        bus.in_data  = 12'h001;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midreset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset result", {19'd0, bus.sign_out, bus.exp_out, bus.frac_out}, 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        checkOutput("midreset no pulse", 32'(pulses), 32'd0);
        applyStimulus(12'h064, vecs[2].want, 0, 1'b0, '0, "after reset");

        $display("[TB] random vectors against reference model");
        for (int i = 0; i < 40; i++) begin
            d = INT_W'($urandom);
            if (i % 4 == 1) d = INT_W'($urandom_range(0, 300)) ^ ((i % 8 == 1) ? '1 : '0);
            want = model(d);
            applyStimulus(d, want, $urandom_range(0, 3), 1'b0, '0, $sformatf("rand %03h", d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: simulation did not complete, expected completion");
        $fatal(1, "[TB] timeout");
    end
endmodule
